// File: rtl/am_mon_pkg.sv
// rtl/am_mon_pkg.sv - shared types and constants for the multiplier error monitor
package am_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // |ED| fits in 2*width bits; cnt_w extra bits absorb a full window without wrap
  function automatic int sum_width(input int width, input int cnt_w);
    return 2 * width + cnt_w;
  endfunction

endpackage

// File: rtl/am_ed_stage.sv
// rtl/am_ed_stage.sv - registered error-distance stage for an approximate multiplier
module am_ed_stage
  import am_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2*WIDTH-1:0] z_approx,
  output logic               out_valid,
  output logic [2*WIDTH:0]   ed,
  output logic [2*WIDTH-1:0] abs_ed,
  output logic               nonzero
);

  logic [2*WIDTH-1:0] exact;
  logic [2*WIDTH:0]   ed_d;
  logic [2*WIDTH:0]   ed_neg;
  logic [2*WIDTH-1:0] abs_d;

  // Exact product and signed difference; one extra bit keeps the sign of z - x*y
  always_comb begin
    exact  = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    ed_d   = {1'b0, z_approx} - {1'b0, exact};
    ed_neg = -ed_d;
    abs_d  = ed_d[2*WIDTH] ? ed_neg[2*WIDTH-1:0] : ed_d[2*WIDTH-1:0];
  end

  // Capture ED for accepted samples; data holds during bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ed        <= '0;
      abs_ed    <= '0;
      nonzero   <= 1'b0;
    end else begin
      out_valid <= valid;
      if (valid) begin
        ed      <= ed_d;
        abs_ed  <= abs_d;
        nonzero <= |ed_d;
      end
    end
  end

endmodule

// File: rtl/am_error_monitor.sv
// rtl/am_error_monitor.sv - windowed error statistics for an approximate multiplier
module am_error_monitor
  import am_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = sum_width(DEF_WIDTH, DEF_CNT_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   win_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2*WIDTH-1:0] z_approx,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_count,
  output logic [CNT_W-1:0]   res_err_count,
  output logic [SUM_W-1:0]   res_sum_abs,
  output logic [SUM_W:0]     res_sum_signed,
  output logic [2*WIDTH-1:0] res_max_abs
);

  mon_state_t state, state_nxt;

  logic [CNT_W-1:0]   win_q;
  logic [CNT_W-1:0]   acc_cnt;
  logic               start_go;
  logic               accept;

  logic               s1_valid;
  logic [2*WIDTH:0]   s1_ed;
  logic [2*WIDTH-1:0] s1_abs;
  logic               s1_nz;

  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   err_q;
  logic [SUM_W-1:0]   sabs_q;
  logic [SUM_W:0]     ssig_q;
  logic [2*WIDTH-1:0] max_q;

  assign accept = in_valid & in_ready;

  am_ed_stage #(
    .WIDTH (WIDTH)
  ) u_ed_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (accept),
    .x         (x),
    .y         (y),
    .z_approx  (z_approx),
    .out_valid (s1_valid),
    .ed        (s1_ed),
    .abs_ed    (s1_abs),
    .nonzero   (s1_nz)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs; start only counts in IDLE
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    start_go  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_go  = 1'b1;
          state_nxt = (win_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = (acc_cnt < win_q);
        if (in_valid && in_ready && ((acc_cnt + CNT_W'(1)) == win_q)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // stage 2 writes the accumulators in place, so an empty stage 1
        // means the final update has already landed
        if (!s1_valid) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window length latch, accepted-sample counter and stage-2 accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= '0;
      acc_cnt <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      sabs_q  <= '0;
      ssig_q  <= '0;
      max_q   <= '0;
    end else if (start_go) begin
      win_q   <= win_len;
      acc_cnt <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      sabs_q  <= '0;
      ssig_q  <= '0;
      max_q   <= '0;
    end else begin
      if (accept) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      if (s1_valid) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        err_q  <= err_q + {{(CNT_W-1){1'b0}}, s1_nz};
        sabs_q <= sabs_q + {{(SUM_W-2*WIDTH){1'b0}}, s1_abs};
        ssig_q <= ssig_q + {{(SUM_W-2*WIDTH){s1_ed[2*WIDTH]}}, s1_ed};
        // strict compare: ties keep the earlier maximum
        if (s1_abs > max_q) begin
          max_q <= s1_abs;
        end
      end
    end
  end

  assign res_count      = cnt_q;
  assign res_err_count  = err_q;
  assign res_sum_abs    = sabs_q;
  assign res_sum_signed = ssig_q;
  assign res_max_abs    = max_q;

endmodule

// File: tb/tb_am_error_monitor.sv
// tb/tb_am_error_monitor.sv - scoreboard bench for the multiplier error monitor
module tb_am_error_monitor;

  localparam int W  = 8;
  localparam int CW = 16;
  localparam int SW = 2 * W + CW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] win_len;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [2*W-1:0] z_approx;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic [CW-1:0] res_err_count;
  logic [SW-1:0] res_sum_abs;
  logic [SW:0]   res_sum_signed;
  logic [2*W-1:0] res_max_abs;

  am_error_monitor #(.WIDTH(W), .CNT_W(CW), .SUM_W(SW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .win_len        (win_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .x              (x),
    .y              (y),
    .z_approx       (z_approx),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_count      (res_count),
    .res_err_count  (res_err_count),
    .res_sum_abs    (res_sum_abs),
    .res_sum_signed (res_sum_signed),
    .res_max_abs    (res_max_abs)
  );

  typedef struct {
    longint count;
    longint err;
    longint sabs;
    longint ssig;
    longint mx;
  } rec_t;

  rec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   sx[8];
  int   sy[8];
  int   sz[8];
  int   sgap[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_rec(input string tag, input rec_t e);
    check({tag, "_count"}, longint'(res_count), e.count);
    check({tag, "_err"},   longint'(res_err_count), e.err);
    check({tag, "_sabs"},  longint'(res_sum_abs), e.sabs);
    check({tag, "_ssig"},  longint'($signed(res_sum_signed)), e.ssig);
    check({tag, "_max"},   longint'(res_max_abs), e.mx);
  endtask

  task automatic set_s(input int i, input int a, input int b, input int c, input int g);
    sx[i] = a; sy[i] = b; sz[i] = c; sgap[i] = g;
  endtask

  // present one sample and wait (bounded) for the accepting edge
  task automatic feed(input string tag, input int i);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    x        = sx[i][W-1:0];
    y        = sy[i][W-1:0];
    z_approx = sz[i][2*W-1:0];
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    z_approx = '0;
    if (!got) check({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic run_window(input string tag, input int len, input int hold,
                            input bit start_noise, input int probe, input longint probe_max);
    rec_t e;
    rec_t got_e;
    longint ed;
    longint a;
    e = '{0, 0, 0, 0, 0};
    for (int i = 0; i < len; i++) begin
      ed = longint'(sz[i]) - longint'(sx[i]) * longint'(sy[i]);
      a  = (ed < 0) ? -ed : ed;
      e.count++;
      if (ed != 0) e.err++;
      e.sabs += a;
      e.ssig += ed;
      if (a > e.mx) e.mx = a;
    end
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    start   = 1'b1;
    win_len = CW'(len);
    @(posedge clk);
    #1;
    start = 1'b0;

    if (len == 0) begin
      @(negedge clk);
      check({tag, "_zl_valid"}, longint'(res_valid), 1);
      check({tag, "_zl_ready"}, longint'(in_ready), 0);
    end else begin
      for (int i = 0; i < len; i++) begin
        for (int g = 0; g < sgap[i]; g++) begin
          @(posedge clk);
          #1;
        end
        feed(tag, i);
        if (i == probe) begin
          @(posedge clk);
          @(negedge clk);
          check({tag, "_probe_max"}, longint'(res_max_abs), probe_max);
          @(posedge clk);
          #1;
        end
      end
      @(negedge clk);
      check({tag, "_lat0"}, longint'(res_valid), 0);
      @(negedge clk);
      check({tag, "_lat1"}, longint'(res_valid), 0);
      @(negedge clk);
      check({tag, "_lat2"}, longint'(res_valid), 1);
      check({tag, "_lat2_ready"}, longint'(in_ready), 0);
    end

    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 0, 1);
    end else begin
      got_e = exp_q.pop_front();
      check_rec(tag, got_e);
      for (int h = 0; h < hold; h++) begin
        if (start_noise && h == 2) begin
          start   = 1'b1;
          win_len = CW'(0);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_hold_valid"}, longint'(res_valid), 1);
        check({tag, "_hold_busy"}, longint'(busy), 1);
        check_rec({tag, "_hold"}, got_e);
      end
      res_ready = 1'b1;
      if (start_noise) start = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      start     = 1'b0;
      @(negedge clk);
      check({tag, "_post_valid"}, longint'(res_valid), 0);
      check({tag, "_post_busy"}, longint'(busy), 0);
      check({tag, "_post_count"}, longint'(res_count), got_e.count);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    win_len   = '0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    z_approx  = '0;
    res_ready = 1'b0;
    #23;
    check("rst_busy", longint'(busy), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_res_valid", longint'(res_valid), 0);
    check_rec("rst", '{0, 0, 0, 0, 0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    set_s(0, 255, 255, 65025, 0);
    run_window("exact", 1, 0, 1'b0, -1, 0);

    set_s(0, 200, 100, 19968, 0);
    set_s(1, 3, 5, 16, 0);
    run_window("mixed", 2, 0, 1'b0, -1, 0);

    set_s(0, 0, 0, 1, 0);
    set_s(1, 0, 0, 0, 2);
    set_s(2, 1, 1, 3, 1);
    run_window("bp", 3, 5, 1'b1, -1, 0);

    run_window("zero", 0, 0, 1'b0, -1, 0);

    // partial window destroyed by asynchronous reset
    @(posedge clk);
    #1;
    start   = 1'b1;
    win_len = CW'(4);
    @(posedge clk);
    #1;
    start = 1'b0;
    set_s(0, 1, 1, 3, 0);
    set_s(1, 2, 2, 1, 0);
    feed("mid", 0);
    feed("mid", 1);
    @(posedge clk);
    @(negedge clk);
    check("mid_count", longint'(res_count), 2);
    check("mid_busy", longint'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_ready", longint'(in_ready), 0);
    check("mid_rst_valid", longint'(res_valid), 0);
    check_rec("mid_rst", '{0, 0, 0, 0, 0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    set_s(0, 2, 2, 4, 0);
    run_window("after_rst", 1, 0, 1'b0, -1, 0);

    set_s(0, 1, 1, 8, 0);
    set_s(1, 4, 4, 9, 0);
    set_s(2, 0, 0, 9, 0);
    run_window("maxtie", 3, 0, 1'b0, 1, 7);

    set_s(0, 15, 17, 250, 1);
    set_s(1, 128, 2, 300, 0);
    set_s(2, 7, 9, 63, 2);
    set_s(3, 255, 1, 0, 0);
    run_window("misc", 4, 2, 1'b0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/am_error_monitor.md
Name: am_error_monitor

Overview:
- Streaming error-statistics stage placed directly downstream of an approximate unsigned WIDTHxWIDTH multiplier.
- Consumes operand pairs (x, y) together with the multiplier's approximate product z_approx, and computes the exact product internally.
- Over a programmable window of samples, accumulates error statistics (count of erroneous samples, sum of |ED|, signed ED sum, max |ED|).
- Presents one result record per window through a valid/ready handshake; used for on-chip characterisation of multiplier variants.

Parameters:
- WIDTH, 8, operand width; products are 2*WIDTH bits.
- CNT_W, 16, width of the window-length and sample counters.
- SUM_W, 2*WIDTH+CNT_W, width of the unsigned |ED| accumulator.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a window (honoured in IDLE only).
- win_len  in  CNT_W  number of samples per window; latched on accepted start.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid&in_ready at a rising edge.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- z_approx  in  2*WIDTH  approximate product for (x, y).
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  result record valid.
- res_ready  in  1  result consumed when res_valid&res_ready.
- res_count  out  CNT_W  samples accumulated.
- res_err_count  out  CNT_W  samples with ED != 0.
- res_sum_abs  out  SUM_W  sum of |ED|.
- res_sum_signed  out  SUM_W+1  two's-complement sum of ED (bias).
- res_max_abs  out  2*WIDTH  maximum |ED|.

Behaviour:
- Definitions: ED = z_approx - x*y, computed as a signed 2*WIDTH+1-bit value. |ED| fits in 2*WIDTH bits. No accumulator ever saturates or wraps within 2^CNT_W-1 samples.
- Reset (asynchronous, active-low): FSM returns to IDLE. Pipeline valid bits, counters and all res_* outputs clear to 0. in_ready=0, busy=0. Reset mid-window discards the partial window entirely.
- FSM IDLE:
  - in_ready=0.
  - On start=1: latch win_len, clear accumulators and accepted/stat counters.
  - Go to RUN if win_len != 0, otherwise go directly to DONE with an all-zero record.
- FSM RUN:
  - in_ready=1 while the accepted count is below the latched win_len.
  - The edge that accepts the final sample moves the FSM to DRAIN; in_ready is 0 from that edge onward.
- FSM DRAIN: waits until both pipeline stages are empty, then moves to DONE.
- FSM DONE:
  - res_valid=1; res_* are stable and hold while res_ready=0.
  - On res_valid&res_ready, move to IDLE. res_valid drops; res_* values are retained until the next start.
- Pipeline, for a sample accepted at edge T:
  - Stage 1 (edge T): register the exact product and the signed ED.
  - Stage 2 (edge T+1): update all accumulators.
  - For the last sample, res_valid is high after edge T+2. Fixed latency, no stalls: input gaps only insert bubbles.
- start is ignored in RUN/DRAIN/DONE, including a start in the same cycle as the res handshake.
- in_valid outside RUN is ignored; x, y and z_approx are don't-care when in_valid=0.
- Max tracking: the register is updated when |ED| > current max (ties keep the old value). It starts at 0.

Decomposition:
- Package am_mon_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - default WIDTH and CNT_W constants;
  - a width helper function for SUM_W.
- Sub-module am_ed_stage: takes x, y, z_approx and a valid bit; produces a registered signed ED, |ED| and a nonzero flag. This is pipeline stage 1 and is reusable by other characterisation blocks.
- Accumulators and FSM stay in am_error_monitor.

Test Plan:
- Exact window: win_len=1, x=255, y=255, z_approx=65025 -> res_count=1, err=0, sum_abs=0, sum_signed=0, max=0. res_valid is high 2 edges after the accepting edge.
- Mixed errors: win_len=2, samples (200,100,19968) and (3,5,16) -> ED -32 and +1. Result: count=2, err=2, sum_abs=33, sum_signed=-31, max=32.
- Backpressure: win_len=3 with in_valid gaps of 0-2 cycles between samples (0,0,1),(0,0,0),(1,1,3) -> count=3, err=2, sum_abs=3, max=2.
  - Hold res_ready=0 for 5 cycles: res_valid stays 1 and outputs stay stable.
  - A start pulse during this hold is ignored (busy remains 1).
- Zero-length window: start with win_len=0 -> in_ready never rises; all-zero record with res_valid high one edge after start.
- Reset mid-window: win_len=4, accept 2 error samples, assert rst_n=0 asynchronously -> all outputs 0 immediately, state IDLE.
  - A following window win_len=1 with (2,2,4) yields count=1, err=0, sum_abs=0.
- Max tie/update: win_len=3 with |ED| sequence 7, 7, 9 -> max=9. Check that the internal max register holds 7 after the second sample.
